load_store_unit: RTL and testbench

- Memory-stage block directly downstream of the execute ALU.
- Consumes the ALU's effective address and the rs2 store value, and runs one data-memory transaction per load/store over a req/ready bus.
- Performs byte-lane steering and write strobes for stores.
- Performs extraction and sign/zero extension for loads, and hands the aligned load result to writeback.
- Multi-cycle: the core sequencer holds in MEMORY until done pulses.

---
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-stage load/store engine that sits behind the execute ALU. It runs
// one data-memory transaction for each accepted load or store over a simple
// req/ready bus. Stores get byte-lane steering and write strobes. Loads get
// lane extraction plus sign or zero extension before the result goes to
// writeback. The core sequencer stays in MEMORY until done pulses.
//
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles allowed without mem_ready before a bus fault (1..255)
//
// Optional build macro:
//   MISALIGN_TRAP_EN  when defined, a misaligned halfword or word access
//                     faults without a bus request. When undefined, the low
//                     address bits are ignored, which forces the access to
//                     natural alignment.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   start               core is in MEMORY; qualifies is_load / is_store
//   is_load, is_store   decoded op type (load wins if both are set)
//   funct3              RV32I size/sign code
//   address, rs2_val    effective address and store data
//   mem_req/we/addr/wdata/wstrb   bus request, held stable until mem_ready
//   mem_ready, mem_rdata          bus completion and read word
//   load_data           extended load result, held until the next accepted op
//   done                one-cycle completion pulse
//   busy                op in flight
//   fault               valid with done: timeout, illegal funct3 or misalignment

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] rs2_val,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        op_load;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;
  logic [7:0]  wait_count;

  logic        new_op;
  logic        op_legal;
  logic        op_misaligned;
  logic [3:0]  new_wstrb;
  logic [31:0] new_wdata;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] ext_data;

  // Decode of the incoming op. This is only meaningful in IDLE.
  always_comb begin
    new_op        = start && (is_load || is_store);
    op_misaligned = 1'b0;
    if (is_load)
      op_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    else
      op_legal = !funct3[2] && (funct3[1:0] != 2'b11);
`ifdef MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   op_misaligned = address[0];
      2'b10:   op_misaligned = |address[1:0];
      default: op_misaligned = 1'b0;
    endcase
`endif
  end

  // Store lane steering. The data is replicated across every lane, so only
  // the strobes depend on the offset. Offset bits below the access size are
  // dropped, which gives natural alignment.
  always_comb begin
    new_wstrb = 4'b1111;
    new_wdata = rs2_val;
    case (funct3[1:0])
      2'b00: begin
        new_wstrb = 4'b0001 << address[1:0];
        new_wdata = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        new_wstrb = 4'b0011 << {address[1], 1'b0};
        new_wdata = {2{rs2_val[15:0]}};
      end
      default: begin
        new_wstrb = 4'b1111;
        new_wdata = rs2_val;
      end
    endcase
  end

  // Load extraction from the word returned on the ready cycle.
  always_comb begin
    byte_shift = mem_rdata >> {op_off, 3'b000};
    half_shift = mem_rdata >> {op_off[1], 4'b0000};
    case (op_funct3)
      3'b000:  ext_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b100:  ext_data = {24'h000000, byte_shift[7:0]};
      3'b001:  ext_data = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b101:  ext_data = {16'h0000, half_shift[15:0]};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_load    <= 1'b0;
      op_funct3  <= 3'b000;
      op_off     <= 2'b00;
      wait_count <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'b0000;
      load_data  <= 32'h0;
      done       <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (new_op) begin
            op_load    <= is_load;
            op_funct3  <= funct3;
            op_off     <= address[1:0];
            wait_count <= 8'd0;
            load_data  <= 32'h0;
            busy       <= 1'b1;
            // Illegal or trapped accesses skip the bus entirely.
            if (!op_legal || op_misaligned) begin
              fault <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              fault     <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= !is_load;
              mem_addr  <= {address[31:2], 2'b00};
              mem_wdata <= new_wdata;
              mem_wstrb <= is_load ? 4'b0000 : new_wstrb;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            load_data <= op_load ? ext_data : 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            state     <= DONE;
          end else if (wait_count == TIMEOUT_LAST) begin
            load_data <= 32'h0;
            fault     <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. The bench drives directed cases
// and randomized cases. A byte-level reference model computes the expected
// strobes, write data, load result, fault and REQ duration from the ISA rules.
// The expectations follow MISALIGN_TRAP_EN in the same way as the RTL build.

module tb_load_store_unit;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] rs2_val;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        busy;
  logic        fault;

  int check_count = 0;
  int error_count = 0;

  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [31:0] obs_load;
  logic [3:0]  obs_strb;
  logic        obs_we;
  logic        obs_fault;
  int          obs_req_cycles;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .address   (address),
    .rs2_val   (rs2_val),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .load_data (load_data),
    .done      (done),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_faults(input bit ld, input logic [2:0] f3,
                                      input logic [31:0] a);
    bit legal;
    if (ld) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((int'(a[1:0]) % access_size(f3)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = access_size(f3);
    return (int'(a[1:0]) / sz) * sz;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int base, sz;
    sz   = access_size(f3);
    base = lane_base(f3, a);
    for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + sz);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int sz;
    sz = access_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [7:0]  b [4];
    logic [31:0] v;
    int base;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    base = lane_base(f3, a);
    case (access_size(f3))
      1: begin
        v = {24'h0, b[base]};
        if (!f3[2] && b[base][7]) v = v | 32'hFFFF_FF00;
      end
      2: begin
        v = {16'h0, b[base+1], b[base]};
        if (!f3[2] && b[base+1][7]) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  // Runs one op through the DUT. The bus answers on REQ cycle `delay`
  // (0-based). If that is at or beyond the timeout, the bus never answers.
  task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] rs2,
                               input int delay, input logic [31:0] rdata);
    bit flt;
    bit timeout;
    int n_req;
    obs_addr = 32'h0; obs_wdata = 32'h0; obs_strb = 4'h0; obs_we = 1'b0;
    obs_req_cycles = 0;
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    address = a; rs2_val = rs2; mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (!ld && !st) begin
      checkOutput("noop_busy", busy, 0);
      checkOutput("noop_req", mem_req, 0);
      checkOutput("noop_done", done, 0);
      return;
    end
    flt     = model_faults(ld, f3, a);
    timeout = !flt && (delay >= TO);
    if (flt)            n_req = 0;
    else if (delay < TO) n_req = delay + 1;
    else                n_req = TO;
    for (int j = 0; j < n_req; j++) begin
      checkOutput("req_high", mem_req, 1);
      checkOutput("req_busy", busy, 1);
      checkOutput("req_done", done, 0);
      checkOutput("req_we", mem_we, {31'b0, !ld});
      checkOutput("req_addr", mem_addr, {a[31:2], 2'b00});
      checkOutput("req_strb", mem_wstrb, ld ? 32'h0 : {28'h0, model_strb(f3, a)});
      if (!ld) checkOutput("req_wdata", mem_wdata, model_wdata(f3, rs2));
      if (mem_req) obs_req_cycles++;
      obs_addr = mem_addr; obs_strb = mem_wstrb; obs_wdata = mem_wdata; obs_we = mem_we;
      mem_ready = (j == delay);
      mem_rdata = (j == delay) ? rdata : $urandom;
      // Junk presented while busy must be ignored.
      start    = ($urandom_range(0, 3) == 0);
      is_load  = 1'($urandom);
      is_store = 1'($urandom);
      funct3   = 3'($urandom);
      address  = $urandom;
      rs2_val  = $urandom;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    start     = 1'b0;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_req", mem_req, 0);
    checkOutput("done_fault", fault, {31'b0, flt || timeout});
    if (ld) checkOutput("done_load", load_data, (flt || timeout) ? 32'h0 : model_load(f3, a, rdata));
    obs_fault = fault;
    obs_load  = load_data;
    @(negedge clk);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_fault_held", fault, {31'b0, obs_fault});
    checkOutput("idle_load_held", load_data, obs_load);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    address = 32'h0; rs2_val = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #12;
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_load", load_data, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_strb", mem_wstrb, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 1, 3'b000, 32'h2001, 32'hDEADBEA5, 0, 32'h0);
    checkOutput("sb_addr", obs_addr, 32'h2000);
    checkOutput("sb_strb", obs_strb, 32'h2);
    checkOutput("sb_wdata", obs_wdata, 32'hA5A5A5A5);
    checkOutput("sb_fault", obs_fault, 0);

    applyStimulus(1, 0, 3'b000, 32'h3003, 32'h0, 0, 32'h80112233);
    checkOutput("lb_data", obs_load, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b100, 32'h3003, 32'h0, 1, 32'h80112233);
    checkOutput("lbu_data", obs_load, 32'h00000080);
    applyStimulus(1, 0, 3'b101, 32'h3002, 32'h0, 2, 32'h80112233);
    checkOutput("lhu_data", obs_load, 32'h00008011);
    applyStimulus(1, 0, 3'b001, 32'h3002, 32'h0, 0, 32'h80112233);
    checkOutput("lh_data", obs_load, 32'hFFFF8011);

    applyStimulus(1, 0, 3'b010, 32'h4000, 32'h0, 5, 32'h12345678);
    checkOutput("lw_slow_data", obs_load, 32'h12345678);
    checkOutput("lw_slow_reqs", obs_req_cycles, 6);

    applyStimulus(1, 0, 3'b010, 32'h4004, 32'h0, 1000, 32'h0);
    checkOutput("to_reqs", obs_req_cycles, TO);
    checkOutput("to_fault", obs_fault, 1);
    checkOutput("to_load", obs_load, 0);

    applyStimulus(1, 0, 3'b011, 32'h5000, 32'h0, 0, 32'h0);
    checkOutput("ill_fault", obs_fault, 1);
    checkOutput("ill_reqs", obs_req_cycles, 0);

    applyStimulus(1, 1, 3'b010, 32'h6000, 32'h11111111, 0, 32'hA0B0C0D0);
    checkOutput("both_we", obs_we, 0);
    checkOutput("both_load", obs_load, 32'hA0B0C0D0);

    applyStimulus(0, 0, 3'b010, 32'h6000, 32'h0, 0, 32'h0);

    applyStimulus(1, 0, 3'b010, 32'h1002, 32'h0, 0, 32'hCAFEF00D);
`ifdef MISALIGN_TRAP_EN
    checkOutput("mis_lw_fault", obs_fault, 1);
    checkOutput("mis_lw_reqs", obs_req_cycles, 0);
`else
    checkOutput("mis_lw_addr", obs_addr, 32'h1000);
    checkOutput("mis_lw_fault", obs_fault, 0);
    checkOutput("mis_lw_data", obs_load, 32'hCAFEF00D);
    applyStimulus(0, 1, 3'b001, 32'h1003, 32'h0000BEEF, 0, 32'h0);
    checkOutput("mis_sh_strb", obs_strb, 32'hC);
    checkOutput("mis_sh_wdata", obs_wdata, 32'hBEEFBEEF);
`endif

    // Reset in the middle of REQ abandons the op with no done pulse.
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    address = 32'h7000; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("mid_req_high", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_req", mem_req, 0);
    checkOutput("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("post_rst_done", done, 0);
      checkOutput("post_rst_busy", busy, 0);
    end

    for (int n = 0; n < 200; n++) begin
      bit ld, st;
      logic [2:0] f3;
      int mode;
      mode = $urandom_range(0, 9);
      ld = (mode < 5) || (mode == 9);
      st = (mode >= 4) && (mode != 9) ? 1'b1 : 1'b0;
      if (mode == 9) begin ld = 1'b0; st = 1'b0; end
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (ld) f3 = 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000);
      else f3 = 3'($urandom_range(0, 2));
      if (ld && f3 == 3'b110) f3 = 3'b010;
      applyStimulus(ld, st, f3, $urandom, $urandom, int'($urandom_range(0, TO + 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
